data_mem_tester: RTL and testbench
==================================

# data_mem_tester

Bus-initiator self-test engine for the data (variable) memory. It drives the same address / MemWrite / WriteData / ReadData interface that the ARM core uses toward the memory decode logic. On START it writes a deterministic pattern to N_WORDS consecutive words, reads them back and compares, then reports pass/fail, an error count and the first failing address. It is muxed onto the data-memory port in place of the core for board bring-up and simulation checks.

## Interface
- N_WORDS, 128: number of 32-bit words tested, at least 1.
- BASE_ADDR, 32'h00000800: byte address of the first word, word-aligned.
- SEED, 32'hA5A5A5A5: pattern seed.
- CLK  in  1  clock; every register updates on the rising edge.
- RESET  in  1  reset, synchronous and active-high.
- START  in  1  level-sampled request to begin a test.
- ABORT  in  1  stops the test and returns to IDLE; has priority over START.
- ReadData  in  32  read data from the memory; combinational response to Addr in the same cycle.
- Addr  out  32  byte address, equivalent to the core's ALUResult.
- MemWrite  out  1  write strobe; the memory writes WriteData to Addr on the rising edge while this is high.
- WriteData  out  32  write data.
- BUSY  out  1  high in WRITE and READ.
- DONE  out  1  high in DONE.
- PASS  out  1  DONE and ERR_COUNT == 0.
- ERR_COUNT  out  8  number of mismatches, saturating at 255.
- FIRST_ERR_ADDR  out  32  Addr of the first mismatch; 0 if there has been none.

## Operation
- Pattern: P(i) = SEED ^ (i * 32'h9E3779B9), where i is the word index zero-extended to 32 bits and the product is truncated modulo 2^32.
- Address: Addr = BASE_ADDR + 4*i, computed in 32 bits.
- States: IDLE, WRITE, READ, DONE. Index counter idx runs 0..N_WORDS-1.
- IDLE:
  - Addr = 0, MemWrite = 0, WriteData = 0. Address 0 lies outside both data decode windows.
  - If START = 1, go to WRITE, clear idx, ERR_COUNT and FIRST_ERR_ADDR.
- WRITE:
  - Addr = addr(idx), MemWrite = 1, WriteData = P(idx).
  - idx increments each cycle.
  - At idx = N_WORDS-1, go to READ with idx = 0.
- READ:
  - Addr = addr(idx), MemWrite = 0, WriteData = 0.
  - At each edge, ReadData is compared with P(idx).
  - On a mismatch, ERR_COUNT increments (held at 255 once saturated). FIRST_ERR_ADDR loads Addr if ERR_COUNT was 0.
  - At idx = N_WORDS-1, go to DONE.
- DONE:
  - Bus outputs as in IDLE.
  - Results hold until the next START.
  - START = 1 clears the results and goes to WRITE, exactly as from IDLE.
- START while BUSY is ignored.
- ABORT = 1 in any state: the next state is IDLE, results are cleared and MemWrite is low from the next cycle. The mismatch comparison on that edge is discarded.
- RESET = 1 overrides everything. On the next edge:
  - state = IDLE
  - all outputs 0: Addr, MemWrite, WriteData, BUSY, DONE, PASS, ERR_COUNT, FIRST_ERR_ADDR
- MemWrite is never high outside WRITE.
- All bus outputs are registered or decoded purely from state and idx. There is no combinational path from ReadData to any output.

## Timing
- Edge t0 samples START in IDLE.
- Edges t0+1 .. t0+N_WORDS: writes, one word per cycle.
- Edges t0+N_WORDS+1 .. t0+2*N_WORDS: read-compares.
- DONE and PASS are valid in the cycle after edge t0+2*N_WORDS; for N_WORDS = 128 that is 256 edges after t0.
- BUSY is high for exactly 2*N_WORDS cycles.
- Back-to-back runs: holding START high through DONE restarts immediately. DONE is then high for exactly one cycle.
- N_WORDS = 1: one WRITE cycle, one READ cycle, then DONE.

## Test plan
- Ideal memory model with defaults: START pulse at t0 → 128 writes, Addr 0x800..0x9FC, WriteData[0] = 0xA5A5A5A5, WriteData[1] = 0xA5A5A5A5 ^ 0x9E3779B9 = 0x3B92DC1C. DONE rises 256 cycles after t0 with PASS = 1, ERR_COUNT = 0, FIRST_ERR_ADDR = 0.
- Memory model with bit 0 stuck at 1 only at 0x804: P(1) bit 0 is 0, so the run ends with ERR_COUNT = 1, FIRST_ERR_ADDR = 0x804, PASS = 0.
- Memory always returning 0, with N_WORDS = 300 in a bench-local memory: ERR_COUNT saturates at 255 and FIRST_ERR_ADDR = 0x800.
- START pulsed again at cycle t0+50: no restart, DONE still at t0+256. START held high after DONE: DONE is high one cycle and the next run's WRITE begins at Addr 0x800.
- ABORT during WRITE at idx 10: the next cycle shows MemWrite = 0, Addr = 0, BUSY = 0 and cleared results. A following START runs a complete pass.
- RESET asserted during READ at idx 40: the next cycle has every output at 0 and state IDLE. A subsequent START completes with PASS = 1.

Source files
------------

// File: rtl/data_mem_tester.sv
// Data-memory self-test initiator: writes a seeded pattern to N_WORDS words,
// reads it back, and reports pass/fail, mismatch count and first failing address.
module data_mem_tester #(
    parameter int unsigned N_WORDS   = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0800,
    parameter logic [31:0] SEED      = 32'hA5A5_A5A5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        ABORT,
    input  logic [31:0] ReadData,
    output logic [31:0] Addr,
    output logic        MemWrite,
    output logic [31:0] WriteData,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [7:0]  ERR_COUNT,
    output logic [31:0] FIRST_ERR_ADDR
);

    localparam int unsigned IdxW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [7:0]      err_q, err_d;
    logic [31:0]     ferr_q, ferr_d;
    logic [31:0]     idx_ext, cur_addr, cur_pat;

    assign idx_ext  = 32'(idx_q);
    assign cur_addr = BASE_ADDR + (idx_ext << 2);
    assign cur_pat  = SEED ^ (idx_ext * 32'h9E37_79B9);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        if (ABORT) begin
            // Any in-flight compare on this edge is dropped along with the results.
            state_d = StIdle;
            idx_d   = '0;
            err_d   = '0;
            ferr_d  = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (START) begin
                        state_d = StWrite;
                        idx_d   = '0;
                        err_d   = '0;
                        ferr_d  = '0;
                    end
                end
                StWrite: begin
                    if (idx_q == LastIdx) begin
                        state_d = StRead;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                StRead: begin
                    if (ReadData != cur_pat) begin
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                        if (err_q == 8'd0) ferr_d = cur_addr;
                    end
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Bus outputs decode from state and idx only; ReadData never reaches them.
    always_comb begin
        Addr      = '0;
        MemWrite  = 1'b0;
        WriteData = '0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        unique case (state_q)
            StWrite: begin
                Addr      = cur_addr;
                MemWrite  = 1'b1;
                WriteData = cur_pat;
                BUSY      = 1'b1;
            end
            StRead: begin
                Addr = cur_addr;
                BUSY = 1'b1;
            end
            StDone:  DONE = 1'b1;
            default: ;
        endcase
        PASS           = DONE && (err_q == 8'd0);
        ERR_COUNT      = err_q;
        FIRST_ERR_ADDR = ferr_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            idx_q   <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
        end
    end

endmodule

// File: tb/tb_data_mem_tester.sv
// Self-checking bench for data_mem_tester: bus scoreboard, run table and
// hand-written abort/reset/restart sequences.
module tb_data_mem_tester;

    localparam logic [31:0] SEED = 32'hA5A5_A5A5;

    logic CLK = 1'b0, RESET = 1'b1, ABORT = 1'b0;
    logic start_a = 1'b0, start_z = 1'b0, start_1 = 1'b0;

    logic [31:0] rd_a, addr_a, wd_a, ferr_a;
    logic        we_a, busy_a, done_a, pass_a;
    logic [7:0]  err_a;
    logic [31:0] addr_z, wd_z, ferr_z;
    logic        we_z, busy_z, done_z, pass_z;
    logic [7:0]  err_z;
    logic [31:0] rd_1, addr_1, wd_1, ferr_1;
    logic        we_1, busy_1, done_1, pass_1;
    logic [7:0]  err_1;

    data_mem_tester dut (
        .CLK(CLK), .RESET(RESET), .START(start_a), .ABORT(ABORT), .ReadData(rd_a),
        .Addr(addr_a), .MemWrite(we_a), .WriteData(wd_a), .BUSY(busy_a), .DONE(done_a),
        .PASS(pass_a), .ERR_COUNT(err_a), .FIRST_ERR_ADDR(ferr_a)
    );

    data_mem_tester #(.N_WORDS(300)) dut_z (
        .CLK(CLK), .RESET(RESET), .START(start_z), .ABORT(ABORT), .ReadData(32'h0),
        .Addr(addr_z), .MemWrite(we_z), .WriteData(wd_z), .BUSY(busy_z), .DONE(done_z),
        .PASS(pass_z), .ERR_COUNT(err_z), .FIRST_ERR_ADDR(ferr_z)
    );

    data_mem_tester #(.N_WORDS(1)) dut_1 (
        .CLK(CLK), .RESET(RESET), .START(start_1), .ABORT(ABORT), .ReadData(rd_1),
        .Addr(addr_1), .MemWrite(we_1), .WriteData(wd_1), .BUSY(busy_1), .DONE(done_1),
        .PASS(pass_1), .ERR_COUNT(err_1), .FIRST_ERR_ADDR(ferr_1)
    );

    always #5 CLK = ~CLK;

    // Memory models: main one has an optional stuck-at-1 on bit 0 at 0x804.
    logic [31:0] mem [0:1023];
    logic [31:0] mem1;
    bit          stuck = 1'b0;

    always_comb begin
        rd_a = mem[addr_a[11:2]];
        if (stuck && addr_a == 32'h804) rd_a[0] = 1'b1;
    end
    always @(posedge CLK) if (we_a) mem[addr_a[11:2]] <= wd_a;
    always @(posedge CLK) if (we_1) mem1 <= wd_1;
    assign rd_1 = mem1;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
    } bus_t;
    typedef struct {
        bit          stuck;
        logic [7:0]  err;
        logic [31:0] ferr;
        bit          pass;
    } run_t;
    typedef struct {
        int          idx;
        logic [31:0] data;
    } vec_t;

    bus_t        sb_q[$];
    logic [31:0] cap [0:1023];
    run_t        runs[3];
    vec_t        vecs[3];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] pat(input int unsigned i);
        return SEED ^ (32'(i) * 32'h9E37_79B9);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_run();
        for (int i = 0; i < 128; i++) sb_q.push_back({32'h800 + 32'(4 * i), 1'b1, pat(i)});
        for (int i = 0; i < 128; i++) sb_q.push_back({32'h800 + 32'(4 * i), 1'b0, 32'h0});
    endtask

    // Advance one edge, then check the main DUT bus against the scoreboard.
    task automatic tick();
        bus_t e;
        @(posedge CLK);
        #1;
        if (busy_a) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_busy", {31'h0, busy_a}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk("bus_addr", addr_a, e.addr);
                chk("bus_we", {31'h0, we_a}, {31'h0, e.we});
                chk("bus_wdata", wd_a, e.wd);
            end
            if (we_a) cap[addr_a[11:2]] = wd_a;
        end else begin
            chk("idle_memwrite", {31'h0, we_a}, 32'h0);
        end
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return done_a;
            1:       return done_z;
            default: return done_1;
        endcase
    endfunction

    task automatic wait_done(input string nm, input int n0, input int exp_n, input int sel);
        int n = n0;
        while (!done_of(sel) && n < 4000) begin
            tick();
            n++;
        end
        chk(nm, 32'(n), 32'(exp_n));
    endtask

    task automatic start_main(input bit hold);
        start_a = 1'b1;
        push_run();
        tick();
        if (!hold) start_a = 1'b0;
    endtask

    task automatic check_results(input string nm, input logic [7:0] err,
                                 input logic [31:0] ferr, input bit pass);
        chk({nm, "_done"}, {31'h0, done_a}, 32'h1);
        chk({nm, "_pass"}, {31'h0, pass_a}, {31'h0, pass});
        chk({nm, "_err"}, {24'h0, err_a}, {24'h0, err});
        chk({nm, "_ferr"}, ferr_a, ferr);
        chk({nm, "_busy"}, {31'h0, busy_a}, 32'h0);
        chk({nm, "_addr"}, addr_a, 32'h0);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_addr"}, addr_a, 32'h0);
        chk({nm, "_we"}, {31'h0, we_a}, 32'h0);
        chk({nm, "_wd"}, wd_a, 32'h0);
        chk({nm, "_flags"}, {29'h0, busy_a, done_a, pass_a}, 32'h0);
        chk({nm, "_err"}, {24'h0, err_a}, 32'h0);
        chk({nm, "_ferr"}, ferr_a, 32'h0);
    endtask

    initial begin
        runs[0] = '{stuck: 1'b0, err: 8'd0, ferr: 32'h0,   pass: 1'b1};
        runs[1] = '{stuck: 1'b0, err: 8'd0, ferr: 32'h0,   pass: 1'b1};
        runs[2] = '{stuck: 1'b1, err: 8'd1, ferr: 32'h804, pass: 1'b0};
        vecs[0] = '{idx: 0, data: 32'hA5A5_A5A5};
        vecs[1] = '{idx: 1, data: 32'h3B92_DC1C};
        vecs[2] = '{idx: 2, data: 32'h99CB_56D7};

        tick();
        tick();
        check_all_zero("reset");
        chk("reset_other_busy", {30'h0, busy_z, busy_1}, 32'h0);
        RESET = 1'b0;
        tick();

        for (int r = 0; r < 3; r++) begin
            stuck = runs[r].stuck;
            start_main(1'b0);
            wait_done("run_latency", 0, 256, 0);
            check_results("run", runs[r].err, runs[r].ferr, runs[r].pass);
            tick();
            chk("run_done_hold", {31'h0, done_a}, 32'h1);
            chk("run_err_hold", {24'h0, err_a}, {24'h0, runs[r].err});
        end
        for (int v = 0; v < 3; v++)
            chk("pattern_vec", cap[512 + vecs[v].idx], vecs[v].data);

        // ABORT from DONE clears the failing results.
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        stuck = 1'b0;
        check_all_zero("abort_done");

        // START pulsed mid-run is ignored.
        start_main(1'b0);
        repeat (49) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done("restart_ignored", 50, 256, 0);
        check_results("restart_ignored", 8'd0, 32'h0, 1'b1);

        // START held: DONE lasts one cycle, next run starts at 0x800.
        start_main(1'b1);
        wait_done("b2b_first", 0, 256, 0);
        check_results("b2b_first", 8'd0, 32'h0, 1'b1);
        push_run();
        tick();
        chk("b2b_done_1cyc", {31'h0, done_a}, 32'h0);
        chk("b2b_addr", addr_a, 32'h800);
        start_a = 1'b0;
        wait_done("b2b_second", 0, 256, 0);
        check_results("b2b_second", 8'd0, 32'h0, 1'b1);

        // ABORT during WRITE at idx 10.
        start_main(1'b0);
        repeat (10) tick();
        chk("abort_w_pre", {31'h0, we_a}, 32'h1);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check_all_zero("abort_write");
        sb_q.delete();
        start_main(1'b0);
        wait_done("abort_rerun", 0, 256, 0);
        check_results("abort_rerun", 8'd0, 32'h0, 1'b1);

        // ABORT on the mismatching read edge discards that compare.
        stuck = 1'b1;
        start_main(1'b0);
        repeat (129) tick();
        chk("abort_r_addr", addr_a, 32'h804);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check_all_zero("abort_read");
        sb_q.delete();
        stuck = 1'b0;

        // RESET during READ at idx 40.
        start_main(1'b0);
        repeat (168) tick();
        chk("reset_r_addr", addr_a, 32'h800 + 32'd160);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_all_zero("reset_read");
        sb_q.delete();
        tick();
        start_main(1'b0);
        wait_done("reset_rerun", 0, 256, 0);
        check_results("reset_rerun", 8'd0, 32'h0, 1'b1);

        // Memory reading all zeros with 300 words: count saturates.
        start_z = 1'b1;
        tick();
        start_z = 1'b0;
        wait_done("sat_latency", 0, 600, 1);
        chk("sat_err", {24'h0, err_z}, 32'hFF);
        chk("sat_ferr", ferr_z, 32'h800);
        chk("sat_pass", {31'h0, pass_z}, 32'h0);

        // Single-word configuration.
        start_1 = 1'b1;
        tick();
        start_1 = 1'b0;
        chk("n1_w_addr", addr_1, 32'h800);
        chk("n1_w_we", {31'h0, we_1}, 32'h1);
        chk("n1_w_data", wd_1, 32'hA5A5_A5A5);
        chk("n1_w_busy", {31'h0, busy_1}, 32'h1);
        tick();
        chk("n1_r_we", {31'h0, we_1}, 32'h0);
        chk("n1_r_addr", addr_1, 32'h800);
        chk("n1_r_busy", {31'h0, busy_1}, 32'h1);
        tick();
        chk("n1_done", {31'h0, done_1}, 32'h1);
        chk("n1_pass", {31'h0, pass_1}, 32'h1);
        chk("n1_err", {24'h0, err_1}, 32'h0);
        chk("n1_busy", {31'h0, busy_1}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
